// File: rtl/mem_stream_reader.sv
// Walks a range of data memory through a borrowed read port and streams each
// word with its address on a valid/ready output; supports repeat and abort.
module mem_stream_reader #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8,
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_STEP   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic                   busy,
  output logic                   done
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   cont_q, cont_d;
  logic [LAT_W-1:0]       wait_q, wait_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   bus_req_q, bus_req_d;
  logic                   rd_en_q, rd_en_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state, datapath and output decode; outputs are registered from state_d.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    cont_d      = cont_q;
    wait_d      = wait_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          count_d     = word_count;
          cont_d      = continuous;
          cur_addr_d  = base_addr;
          remaining_d = word_count;
          state_d     = (word_count == '0) ? S_DONE : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_d = S_READ;
        end else begin
          state_d = S_REQ;
        end
      end
      S_READ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == LAT_LAST) begin
          out_data_d = mem_data_in;
          out_addr_d = cur_addr_q;
          state_d    = S_PRESENT;
        end else begin
          wait_d = wait_q + LAT_W'(1);
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(ADDR_STEP);
          remaining_d = remaining_q - COUNT_WIDTH'(1);
          state_d     = (remaining_q == COUNT_WIDTH'(1)) ? S_DONE : S_REQ;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_DONE: begin
        if (cont_q) begin
          cur_addr_d  = base_q;
          remaining_d = count_q;
          state_d     = (count_q == '0) ? S_IDLE : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides the transition but keeps any transfer accepted this cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end

    if (state_d == S_READ) begin
      mem_addr_d = cur_addr_q;
    end else begin
      mem_addr_d = mem_addr_d;
    end

    bus_req_d = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_WAIT);
    rd_en_d   = (state_d == S_READ);
    valid_d   = (state_d == S_PRESENT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      base_q      <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      cont_q      <= 1'b0;
      wait_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      mem_addr_q  <= '0;
      bus_req_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      cont_q      <= cont_d;
      wait_q      <= wait_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      mem_addr_q  <= mem_addr_d;
      bus_req_q   <= bus_req_d;
      rd_en_q     <= rd_en_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
